// File: rtl/mem_access_master.sv
// Load/store initiator for the common-memory bus.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module mem_access_master #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] Adr,
    output logic [31:0] MWD,
    output logic        MWR,
    output logic        MOE,
    input  logic [31:0] MRD
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

    state_t      state_q;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        err_d;

    // Replace only the addressed lane of the old word.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [1:0]  sz,
                                          input logic [1:0]  a);
        logic [31:0] r;
        r = old;
        case (sz)
            2'b00:   r[{a, 3'b000} +: 8] = wd[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pull the addressed lane out of a word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  sz,
                                            input logic        un,
                                            input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = un ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = un ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Request is illegal: bad size, misaligned or beyond the memory.
    always_comb begin
        err_d = 1'b0;
        if (req_size == 2'b11)
            err_d = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            err_d = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            err_d = 1'b1;
        if (req_addr[31:2] >= LIMIT)
            err_d = 1'b1;
    end

    assign req_ready = (state_q == IDLE);

    // Transaction FSM with registered memory and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            wdata_q    <= 32'h0;
            Adr        <= 32'h0;
            MWD        <= 32'h0;
            MWR        <= 1'b0;
            MOE        <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (err_d) begin
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_we && req_size == 2'b10) begin
                            state_q <= WRITE;
                            Adr     <= {2'b00, req_addr[31:2]};
                            MWD     <= req_wdata;
                            MWR     <= 1'b1;
                        end else begin
                            state_q <= READ;
                            Adr     <= {2'b00, req_addr[31:2]};
                            MOE     <= 1'b1;
                        end
                    end
                end
                READ: begin
                    MOE <= 1'b0;
                    if (we_q) begin
                        state_q <= WRITE;
                        MWR     <= 1'b1;
                        MWD     <= merge(MRD, wdata_q, size_q, lane_q);
                    end else begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extract(MRD, size_q, uns_q, lane_q);
                    end
                end
                WRITE: begin
                    state_q    <= RESP;
                    MWR        <= 1'b0;
                    MWD        <= 32'h0;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                end
                default: begin
                    state_q    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a negedge-write memory model.
// Expected values are hand-computed constants.
module tb_mem_access_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] Adr;
    logic [31:0] MWD;
    logic        MWR;
    logic        MOE;
    logic [31:0] MRD;

    logic [31:0] mem [64];

    int n_chk;
    int n_fail;

    int          r_lat;
    logic        r_err;
    logic [31:0] r_rdata;
    int          r_mwr;
    int          r_moe;
    logic [31:0] r_mwd;
    logic [31:0] r_adr;

    mem_access_master #(.MEM_WORDS(64)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .Adr(Adr),
        .MWD(MWD),
        .MWR(MWR),
        .MOE(MOE),
        .MRD(MRD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write commits on negedge.
    assign MRD = MOE ? mem[Adr[5:0]] : 32'h0;
    always @(negedge clk) begin
        if (MWR) mem[Adr[5:0]] <= MWD;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and observe it until its response (8-cycle bound).
    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic un, input logic [31:0] a,
                          input logic [31:0] wd);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_unsigned = ~un;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = 32'h0BAD_0BAD;
        r_lat   = 0;
        r_err   = 1'b0;
        r_rdata = 32'h0;
        r_mwr   = 0;
        r_moe   = 0;
        r_mwd   = 32'h0;
        r_adr   = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (MWR) begin
                r_mwr++;
                r_mwd = MWD;
                r_adr = Adr;
            end
            if (MOE) begin
                r_moe++;
                r_adr = Adr;
            end
            if (resp_valid) begin
                r_lat   = k;
                r_err   = resp_err;
                r_rdata = resp_rdata;
                break;
            end
        end
    endtask

    logic [31:0] addrs [3];
    logic [31:0] got   [3];
    int          acc_cyc [3];
    int          n_acc;
    int          n_resp;
    int          viol;
    int          rv_seen;
    logic        acc_now;

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[5]  = 32'h5566_7788;
        mem[63] = 32'h8000_0001;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_adr", Adr, 32'h0);
        check("rst_mwd", MWD, 32'h0);
        check("rst_mwr_moe", {30'h0, MWR, MOE}, 32'h0);
        check("rst_resp", {31'h0, resp_valid | resp_err}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        rst = 1'b0;

        // Word store
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("wst_lat", 32'(r_lat), 32'd2);
        check("wst_err", 32'(r_err), 32'd0);
        check("wst_mwr", 32'(r_mwr), 32'd1);
        check("wst_adr", r_adr, 32'd4);
        check("wst_mwd", r_mwd, 32'hDEAD_BEEF);
        check("wst_mem", mem[4], 32'hDEAD_BEEF);
        check("wst_mwd0", MWD, 32'h0);

        // Word load
        do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        check("wld_lat", 32'(r_lat), 32'd2);
        check("wld_moe", 32'(r_moe), 32'd1);
        check("wld_rdata", r_rdata, 32'hDEAD_BEEF);
        check("wld_adr_hold", Adr, 32'd4);

        // Byte store RMW
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AA);
        check("bst_lat", 32'(r_lat), 32'd3);
        check("bst_mwd", r_mwd, 32'hAAAD_BEEF);
        check("bst_mem", mem[4], 32'hAAAD_BEEF);
        check("bst_rdata", r_rdata, 32'h0);

        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check("bld_s", r_rdata, 32'hFFFF_FFAA);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check("bld_u", r_rdata, 32'h0000_00AA);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check("hld_s", r_rdata, 32'hFFFF_AAAD);

        // Half store lower lane, then byte load lane 1
        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF_1234);
        check("hst_lat", 32'(r_lat), 32'd3);
        check("hst_mem", mem[4], 32'hAAAD_1234);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        check("bld_l1", r_rdata, 32'h0000_0012);

        // Errors
        do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5555);
        check("err_h_lat", 32'(r_lat), 32'd1);
        check("err_h_err", 32'(r_err), 32'd1);
        check("err_h_mwr", 32'(r_mwr), 32'd0);
        check("err_h_mem", mem[4], 32'hAAAD_1234);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        check("err_rng_err", 32'(r_err), 32'd1);
        check("err_rng_moe", 32'(r_moe), 32'd0);
        check("err_rng_lat", 32'(r_lat), 32'd1);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        check("err_sz", 32'(r_err), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        check("err_walign", 32'(r_err), 32'd1);

        // Last word in range
        do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
        check("last_err", 32'(r_err), 32'd0);
        check("last_rdata", r_rdata, 32'h8000_0001);

        // Back-to-back loads with req_valid held high
        addrs[0] = 32'h10;
        addrs[1] = 32'h14;
        addrs[2] = 32'hFC;
        n_acc  = 0;
        n_resp = 0;
        viol   = 0;
        for (int i = 0; i < 3; i++) begin
            got[i]     = 32'h0;
            acc_cyc[i] = 0;
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = addrs[0];
        for (int c = 0; c < 30 && n_resp < 3; c++) begin
            if ((MOE || resp_valid) && req_ready) viol++;
            if (resp_valid && n_resp < 3) begin
                got[n_resp] = resp_rdata;
                n_resp++;
            end
            acc_now = req_ready && req_valid;
            @(posedge clk);
            if (acc_now && n_acc < 3) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                #1;
                if (n_acc < 3) req_addr = addrs[n_acc];
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_nresp", 32'(n_resp), 32'd3);
        check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        check("b2b_ready", 32'(viol), 32'd0);
        check("b2b_d0", got[0], 32'hAAAD_1234);
        check("b2b_d1", got[1], 32'h5566_7788);
        check("b2b_d2", got[2], 32'h8000_0001);

        // Reset during WRITE before the negedge
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h14;
        req_wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rw_mwr_on", 32'(MWR), 32'd1);
        rst = 1'b1;
        #1;
        check("rw_mwr_off", {30'h0, MWR, MOE}, 32'h0);
        rv_seen = 0;
        @(negedge clk);
        if (resp_valid) rv_seen++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        check("rw_mem", mem[5], 32'h5566_7788);
        check("rw_noresp", 32'(rv_seen), 32'd0);
        check("rw_ready", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
